// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control and the ALU itself:
// ALUOp codes from main control, R-type funct codes, and 3-bit ALU selects.
package alu_ctrl_pkg;

  typedef logic [1:0] aluop_t;
  typedef logic [5:0] funct_t;
  typedef logic [2:0] sel_t;

  localparam aluop_t ALUOP_ADD   = 2'b00;
  localparam aluop_t ALUOP_SUB   = 2'b01;
  localparam aluop_t ALUOP_RTYPE = 2'b10;
  localparam aluop_t ALUOP_RSVD  = 2'b11;

  localparam funct_t F_ADD  = 6'b100000;
  localparam funct_t F_ADDU = 6'b100001;
  localparam funct_t F_SUB  = 6'b100010;
  localparam funct_t F_SUBU = 6'b100011;
  localparam funct_t F_AND  = 6'b100100;
  localparam funct_t F_OR   = 6'b100101;
  localparam funct_t F_XOR  = 6'b100110;
  localparam funct_t F_NOR  = 6'b100111;
  localparam funct_t F_SLT  = 6'b101010;

  // 3'b101 is intentionally unassigned.
  localparam sel_t SEL_AND = 3'b000;
  localparam sel_t SEL_OR  = 3'b001;
  localparam sel_t SEL_ADD = 3'b010;
  localparam sel_t SEL_XOR = 3'b011;
  localparam sel_t SEL_NOR = 3'b100;
  localparam sel_t SEL_SUB = 3'b110;
  localparam sel_t SEL_SLT = 3'b111;

endpackage

// File: rtl/execution_alu_decode.sv
// Combinational ALUOp/funct decode into the next ALU select and illegal flag.
// Unsupported or unknown codes fall back to ADD with illegal raised.
module execution_alu_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [2:0] sel_nxt,
  output logic       illegal_nxt
);

  always_comb begin
    sel_nxt     = SEL_ADD;
    illegal_nxt = 1'b0;
    case (ALUOp)
      ALUOP_ADD: sel_nxt = SEL_ADD;
      ALUOP_SUB: sel_nxt = SEL_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: sel_nxt = SEL_ADD;
          F_SUB, F_SUBU: sel_nxt = SEL_SUB;
          F_AND:         sel_nxt = SEL_AND;
          F_OR:          sel_nxt = SEL_OR;
          F_XOR:         sel_nxt = SEL_XOR;
          F_NOR:         sel_nxt = SEL_NOR;
          F_SLT:         sel_nxt = SEL_SLT;
          default:       illegal_nxt = 1'b1;
        endcase
      end
      ALUOP_RSVD: illegal_nxt = 1'b1;
      // X/Z on ALUOp lands here and is treated as unsupported.
      default:    illegal_nxt = 1'b1;
    endcase
  end

endmodule

// File: rtl/execution_alu_control.sv
// MIPS EX-stage ALU control: decode plus one enable-gated register stage,
// asynchronously reset to ADD / not-illegal.
module execution_alu_control
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [2:0] select,
  output logic       illegal
);

  logic [2:0] sel_nxt;
  logic       illegal_nxt;

  execution_alu_decode u_decode (
    .ALUOp       (ALUOp),
    .funct       (funct),
    .sel_nxt     (sel_nxt),
    .illegal_nxt (illegal_nxt)
  );

  // en = 0 is a pipeline stall: hold the previous decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select  <= SEL_ADD;
      illegal <= 1'b0;
    end else if (en) begin
      select  <= sel_nxt;
      illegal <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_execution_alu_control.sv
// Self-checking bench for execution_alu_control: directed scenarios plus
// randomized traffic against a table-driven reference model.
module tb_execution_alu_control;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] ALUOp;
  logic [5:0] funct;
  logic [2:0] select;
  logic       illegal;

  int n_cmp;
  int n_bad;

  // Reference state: what the registered outputs should show.
  logic [2:0] exp_sel;
  logic       exp_ill;

  // funct value (decimal) -> select value, for the R-type instructions supported.
  int sel_of_funct [int];

  execution_alu_control dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ALUOp   (ALUOp),
    .funct   (funct),
    .select  (select),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [2:0] s, output logic il);
    int fi;
    s  = 3'd2;
    il = 1'b0;
    fi = int'(f);
    if ($isunknown(op)) il = 1'b1;
    else if (op == 2'd0) s = 3'd2;
    else if (op == 2'd1) s = 3'd6;
    else if (op == 2'd2 && !$isunknown(f) && sel_of_funct.exists(fi)) s = 3'(sel_of_funct[fi]);
    else il = 1'b1;
  endfunction

  // Apply one input set at the falling edge, advance past the next rising edge.
  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic e);
    logic [2:0] s;
    logic       il;
    @(negedge clk);
    ALUOp = op;
    funct = f;
    en    = e;
    ref_decode(op, f, s, il);
    if (e && !rst) begin
      exp_sel = s;
      exp_ill = il;
    end
    @(posedge clk);
    #1;
    $display("txn op=%b funct=%b en=%b -> select=%b illegal=%b (model %b/%b)",
             op, f, e, select, illegal, exp_sel, exp_ill);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    en    = 1'b1;
    ALUOp = 2'b10;
    funct = 6'b101010;
    #2;
    n_cmp++;
    if (select !== 3'b010 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_immediate: got select=%b illegal=%b, want 010/0", select, illegal);
    end
    @(posedge clk);
    #1;
    ALUOp = 2'b11;
    @(posedge clk);
    #1;
    n_cmp++;
    if (select !== 3'b010 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: got select=%b illegal=%b, want 010/0", select, illegal);
    end
    @(negedge clk);
    rst     = 1'b0;
    exp_sel = 3'b010;
    exp_ill = 1'b0;
  endtask

  task automatic test_directed;
    logic [5:0] fl [5];
    logic [2:0] sl [5];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    sl = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    drive(2'b00, 6'b000000, 1'b1);
    n_cmp++;
    if (select !== 3'b010 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL aluop_add: got %b/%b, want 010/0", select, illegal);
    end
    drive(2'b01, 6'b000000, 1'b1);
    n_cmp++;
    if (select !== 3'b110 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL aluop_sub: got %b/%b, want 110/0", select, illegal);
    end
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, fl[i], 1'b1);
      n_cmp++;
      if (select !== sl[i] || illegal !== 1'b0) begin
        n_bad++;
        $display("FAIL rtype_%0d: got %b/%b, want %b/0", i, select, illegal, sl[i]);
      end
    end
  endtask

  task automatic test_illegal;
    drive(2'b10, 6'b001000, 1'b1);
    n_cmp++;
    if (select !== 3'b010 || illegal !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_funct: got %b/%b, want 010/1", select, illegal);
    end
    drive(2'b11, 6'b100100, 1'b1);
    n_cmp++;
    if (select !== 3'b010 || illegal !== 1'b1) begin
      n_bad++;
      $display("FAIL rsvd_aluop: got %b/%b, want 010/1", select, illegal);
    end
    drive(2'b10, 6'b100111, 1'b1);
    n_cmp++;
    if (select !== 3'b100 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL nor_after_illegal: got %b/%b, want 100/0", select, illegal);
    end
  endtask

  task automatic test_stall;
    drive(2'b01, 6'b000000, 1'b1);
    n_cmp++;
    if (select !== 3'b110) begin
      n_bad++;
      $display("FAIL stall_load: got %b, want 110", select);
    end
    drive(2'b10, 6'b100101, 1'b0);
    n_cmp++;
    if (select !== 3'b110 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_hold: got %b/%b, want 110/0", select, illegal);
    end
    drive(2'b10, 6'b100101, 1'b1);
    n_cmp++;
    if (select !== 3'b001) begin
      n_bad++;
      $display("FAIL stall_release: got %b, want 001", select);
    end
  endtask

  task automatic test_async_reset;
    drive(2'b10, 6'b101010, 1'b1);
    n_cmp++;
    if (select !== 3'b111) begin
      n_bad++;
      $display("FAIL pre_reset_slt: got %b, want 111", select);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (select !== 3'b010 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %b/%b, want 010/0", select, illegal);
    end
    exp_sel = 3'b010;
    exp_ill = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (select !== 3'b010) begin
      n_bad++;
      $display("FAIL async_reset_hold: got %b, want 010", select);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(2'b01, 6'b000000, 1'b1);
    n_cmp++;
    if (select !== 3'b110 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_sub: got %b/%b, want 110/0", select, illegal);
    end
  endtask

  task automatic test_random;
    logic [5:0] legal [9];
    logic [1:0] op;
    logic [5:0] f;
    logic       e;
    legal = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42};
    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) f = legal[$urandom_range(0, 8)];
      else f = 6'($urandom);
      e = ($urandom_range(0, 3) != 0);
      drive(op, f, e);
      n_cmp++;
      if (select !== exp_sel || illegal !== exp_ill) begin
        n_bad++;
        $display("FAIL random_%0d: op=%b funct=%b en=%b got %b/%b, want %b/%b",
                 i, op, f, e, select, illegal, exp_sel, exp_ill);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sel_of_funct[32] = 2;
    sel_of_funct[33] = 2;
    sel_of_funct[34] = 6;
    sel_of_funct[35] = 6;
    sel_of_funct[36] = 0;
    sel_of_funct[37] = 1;
    sel_of_funct[38] = 3;
    sel_of_funct[39] = 4;
    sel_of_funct[42] = 7;
    exp_sel = 3'b010;
    exp_ill = 1'b0;

    test_reset();
    test_directed();
    test_illegal();
    test_stall();
    test_async_reset();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
